// File: rtl/bus_pkg.sv
// Shared constants for the serial bus master port: default widths, header layout
// and the controller state encoding.
package bus_pkg;

    localparam int ADDR_W_DEF      = 14;
    localparam int DATA_W_DEF      = 8;
    localparam int ACK_TIMEOUT_DEF = 15;

    // The header carries the address, then read_en, then the 3-bit burst length.
    localparam int HDR_FIELDS_W = 4;
    localparam int HDR_LEN      = ADDR_W_DEF + HDR_FIELDS_W;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ARB      = 3'd1;
    localparam logic [2:0] ST_HEADER   = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK = 3'd3;
    localparam logic [2:0] ST_WDATA    = 3'd4;
    localparam logic [2:0] ST_RDATA    = 3'd5;
    localparam logic [2:0] ST_DONE     = 3'd6;

endpackage

// File: rtl/bus_shift_reg.sv
// Shift register used by the master port: parallel load feeding the serial transmit
// line MSB first, and serial-in from the LSB side to assemble received bytes.
module bus_shift_reg #(
    parameter int W     = 18,
    parameter int OUT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [W-1:0]     load_val_i,
    input  logic             shift_i,
    input  logic             ser_i,
    output logic             ser_o,
    output logic [OUT_W-1:0] par_o
);

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    // A load replaces whatever is left of the previous field, so it wins over a shift.
    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = load_val_i;
        end else if (shift_i) begin
            sr_d = {sr_q[W-2:0], ser_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign ser_o = sr_q[W-1];
    assign par_o = sr_q[OUT_W-1:0];

endmodule

// File: rtl/bus_master_port.sv
// Serial bus master: arbitrates for the bus, sends an address/command header, waits
// for the slave acknowledge, then streams write bytes out or collects read bytes in.
module bus_master_port
    import bus_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              read_en,
    input  logic [2:0]        burst_mode,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              request,
    output logic              bus_req,
    input  logic              bus_grant,
    output logic              tx_bit,
    output logic              tx_valid,
    input  logic              rx_bit,
    input  logic              rx_valid,
    input  logic              slave_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_valid,
    output logic              error
);

    localparam int HW = ADDR_W + HDR_FIELDS_W;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    logic [2:0]        state_q, state_d;
    logic              enable_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rd_q, rd_d;
    logic [2:0]        burst_q, burst_d;
    logic [4:0]        bit_q, bit_d;
    logic [2:0]        beat_q, beat_d;
    logic [TW-1:0]     wait_q, wait_d;
    logic              error_q, error_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_vld_q, dout_vld_d;

    logic              sr_load, sr_shift, tx_shift, rx_shift;
    logic [HW-1:0]     sr_load_val;
    logic              sr_ser;
    logic [DATA_W-2:0] sr_par;
    logic [DATA_W-1:0] next_byte;
    logic              on_bus, abort, enable_rise;

    assign enable_rise = enable & ~enable_q;
    assign on_bus      = (state_q == ST_HEADER) || (state_q == ST_WAIT_ACK) ||
                         (state_q == ST_WDATA)  || (state_q == ST_RDATA);
    assign abort       = on_bus & ~bus_grant;
    assign next_byte   = data_q + DATA_W'(beat_q) + DATA_W'(1);
    assign sr_shift    = tx_shift | rx_shift;

    // Grant loss is checked before any per-state work so a dropped grant never lets
    // another bit or byte complete.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rd_d        = rd_q;
        burst_d     = burst_q;
        bit_d       = bit_q;
        beat_d      = beat_q;
        wait_d      = wait_q;
        error_d     = 1'b0;
        dout_d      = dout_q;
        dout_vld_d  = 1'b0;
        sr_load     = 1'b0;
        sr_load_val = '0;
        tx_shift    = 1'b0;
        rx_shift    = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            error_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable_rise) begin
                        addr_d  = addr_in;
                        data_d  = data_in;
                        rd_d    = read_en;
                        burst_d = burst_mode;
                        state_d = ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (bus_grant) begin
                        sr_load     = 1'b1;
                        sr_load_val = {addr_q, rd_q, burst_q};
                        bit_d       = '0;
                        state_d     = ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    tx_shift = 1'b1;
                    if (bit_q == 5'(HW - 1)) begin
                        wait_d  = '0;
                        state_d = ST_WAIT_ACK;
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end
                ST_WAIT_ACK: begin
                    if (slave_ready) begin
                        bit_d  = '0;
                        beat_d = '0;
                        if (rd_q) begin
                            state_d = ST_RDATA;
                        end else begin
                            sr_load     = 1'b1;
                            sr_load_val = {data_q, {(HW - DATA_W){1'b0}}};
                            state_d     = ST_WDATA;
                        end
                    end else if (wait_q == TW'(ACK_TIMEOUT - 1)) begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        wait_d = wait_q + TW'(1);
                    end
                end
                ST_WDATA: begin
                    tx_shift = 1'b1;
                    if (bit_q == 5'(DATA_W - 1)) begin
                        bit_d = '0;
                        if (beat_q == burst_q) begin
                            state_d = ST_DONE;
                        end else begin
                            beat_d      = beat_q + 3'd1;
                            sr_load     = 1'b1;
                            sr_load_val = {next_byte, {(HW - DATA_W){1'b0}}};
                        end
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end
                ST_RDATA: begin
                    if (rx_valid) begin
                        rx_shift = 1'b1;
                        if (bit_q == 5'(DATA_W - 1)) begin
                            dout_d     = {sr_par, rx_bit};
                            dout_vld_d = 1'b1;
                            bit_d      = '0;
                            if (beat_q == burst_q) begin
                                state_d = ST_DONE;
                            end else begin
                                beat_d = beat_q + 3'd1;
                            end
                        end else begin
                            bit_d = bit_q + 5'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            enable_q   <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            rd_q       <= 1'b0;
            burst_q    <= '0;
            bit_q      <= '0;
            beat_q     <= '0;
            wait_q     <= '0;
            error_q    <= 1'b0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            enable_q   <= enable;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rd_q       <= rd_d;
            burst_q    <= burst_d;
            bit_q      <= bit_d;
            beat_q     <= beat_d;
            wait_q     <= wait_d;
            error_q    <= error_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
        end
    end

    bus_shift_reg #(
        .W     (HW),
        .OUT_W (DATA_W - 1)
    ) u_shift (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (sr_load),
        .load_val_i (sr_load_val),
        .shift_i    (sr_shift),
        .ser_i      (rx_bit),
        .ser_o      (sr_ser),
        .par_o      (sr_par)
    );

    // The transmit line is gated by the live grant so a lost grant silences it at once.
    assign tx_valid       = ((state_q == ST_HEADER) || (state_q == ST_WDATA)) && bus_grant;
    assign tx_bit         = tx_valid & sr_ser;
    assign request        = (state_q != ST_IDLE);
    assign bus_req        = (state_q != ST_IDLE);
    assign data_out       = dout_q;
    assign data_out_valid = dout_vld_q;
    assign error          = error_q;

endmodule

// File: doc/bus_master_port.md
BUS_MASTER_PORT -- requirements
Module: bus_master_port

Interface
REQ-001 Parameter ADDR_W, default 14, meaning full bus address width (upper 2 bits select the slave, lower 12 bits are the in-slave address).
REQ-002 Parameter DATA_W, default 8, meaning data byte width.
REQ-003 Parameter ACK_TIMEOUT, default 15, meaning maximum cycles to wait for slave_ready before aborting.
REQ-004 clk  in  1  single system clock; all state is updated on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (0 = in reset).
REQ-006 enable  in  1  transaction start strobe from the test controller; rising edge is significant.
REQ-007 read_en  in  1  1 = read, 0 = write, sampled with enable.
REQ-008 burst_mode  in  3  extra beats; beats = burst_mode+1 (1..8).
REQ-009 data_in  in  DATA_W  write data for beat 0.
REQ-010 addr_in  in  ADDR_W  start address.
REQ-011 request  out  1  high while a transaction is in progress; consumed by the controller.
REQ-012 bus_req  out  1  arbitration request to the bus arbiter.
REQ-013 bus_grant  in  1  arbiter grant; must remain high for the whole transaction.
REQ-014 tx_bit / tx_valid  out  1/1  serial line to slaves, MSB first.
REQ-015 rx_bit / rx_valid  in  1/1  serial read data from slave, MSB first.
REQ-016 slave_ready  in  1  slave acknowledge after header.
REQ-017 data_out / data_out_valid  out  DATA_W/1  read byte, 1-cycle valid pulse per beat.
REQ-018 error  out  1  1-cycle pulse on abort (timeout or grant loss).

Function
REQ-019 FSM states: IDLE, ARB, HEADER, WAIT_ACK, WDATA, RDATA, DONE.
REQ-020 IDLE: on enable 0->1 capture addr_in, data_in, read_en, burst_mode into registers and go to ARB; enable levels and edges in any other state are ignored.
REQ-021 request is high in every state except IDLE, and rises the cycle after capture.
REQ-022 ARB: bus_req=1; stay until bus_grant=1, then HEADER; bus_req stays 1 until return to IDLE.
REQ-023 HEADER: 18 cycles with tx_valid=1 sending addr[13:0], then read_en, then burst_mode[2:0], all MSB first; then WAIT_ACK.
REQ-024 WAIT_ACK: tx_valid=0; on slave_ready=1 go to WDATA (write) or RDATA (read); after ACK_TIMEOUT cycles without slave_ready, pulse error and go to IDLE.
REQ-025 WDATA: each beat sends 8 bits with tx_valid=1; beat k data = (data_in + k) mod 256; beats sent back to back.
REQ-026 RDATA: shift in rx_bit only on cycles with rx_valid=1; after 8 bits drive data_out and pulse data_out_valid the following cycle.
REQ-027 After the last beat go to DONE for one cycle (bus_req=0, request=0 from the next cycle), then IDLE.
REQ-028 bus_grant=0 in HEADER, WAIT_ACK, WDATA or RDATA aborts: tx_valid=0 immediately, error pulse, IDLE next cycle.
REQ-029 Beat counter wraps never: burst_mode=7 gives exactly 8 beats; bit counter is 5 bits, reset per field.
REQ-030 tx_bit=0 whenever tx_valid=0.

Reset
REQ-031 reset=0 forces state IDLE and all outputs 0 (request, bus_req, tx_bit, tx_valid, data_out, data_out_valid, error) and clears captured registers and counters, asynchronously, including mid-transaction.
REQ-032 The enable edge detector resets to 0, so enable held high through reset release starts a transaction on the first cycle after release.

Structure
REQ-033 Package bus_pkg holds ADDR_W, DATA_W, header length 18, ACK_TIMEOUT default and the state encoding.
REQ-034 One sub-module bus_shift_reg (parallel-load/serial-out, serial-in/parallel-out, width parameter) implements header/data shifting.

Verification
REQ-035 Write addr 1001, data 101, burst 0, grant after 3 cycles, ready after 2 -> header bits 00001111101001,0,000 then byte 0x65; request low after DONE.
REQ-036 Read addr 5097, rx stream 0xA5 with rx_valid gaps -> data_out=0xA5, one data_out_valid pulse, header slave bits 01.
REQ-037 Burst write addr 1001, data 101, burst 5 -> six bytes 101..106 consecutive, request high throughout.
REQ-038 slave_ready never asserted -> error pulse exactly ACK_TIMEOUT cycles into WAIT_ACK, IDLE, bus_req=0.
REQ-039 Drop bus_grant mid-WDATA and separately assert reset mid-HEADER -> tx_valid=0 immediately, error pulse only for grant loss, all outputs 0 under reset.
REQ-040 Second enable edge while busy -> ignored; a new edge after return to IDLE starts a new transaction.
